temp_sensor_i2c_top: RTL and testbench
======================================

// Module: temp_sensor_i2c_top
// PURPOSE
// Top level of the temperature-sensor path. Single-byte I2C master (open-drain SDA/SCL)
// addresses the sensor, either writes a pointer byte or reads one data byte, and latches
// the read value on data_rd. data_rd is shown as unsigned decimal on a 4-digit
// multiplexed 7-segment display.
// PARAMETERS
// CLK_HZ      50_000_000  system clock frequency
// I2C_HZ      100_000     SCL rate; QDIV = CLK_HZ/(4*I2C_HZ) clocks per quarter-bit (min 1)
// SLAVE_ADDR  7'h48       7-bit sensor address
// WR_DATA     8'h00       byte sent in a write transaction (sensor pointer register)
// REFRESH_CYC 50_000      clocks each display digit stays lit
// PORTS
// clk      in     1  system clock; all logic on its rising edge
// reset_n  in     1  synchronous, active-low reset
// ena      in     1  level request: start a transaction whenever idle while high
// ena2     in     1  edge request: each 0->1 transition requests one transaction
// rw       in     1  sampled at start: 1 = read 1 byte, 0 = write WR_DATA
// data_rd  out    8  last byte read from the sensor
// seg      out    8  cathodes {dp,g,f,e,d,c,b,a}, active-low; dp always off (1)
// an       out    4  digit anodes, active-low, one-hot-low; an[0] = units
// sda      inout  1  open-drain: drive 0 or 'z'; external pull-up
// scl      inout  1  open-drain: drive 0 or 'z'; external pull-up
// BEHAVIOUR
// - Synchronous active-low reset: SDA/SCL released (z), FSM IDLE, data_rd=0, pending=0,
//   digit index 0 (an=4'b1110), seg shows '0' (8'b1100_0000).
// - Quarter tick every QDIV clocks, free-running only while not IDLE.
// - Request = ena | ena2 rising edge (registered edge detect). ena2 edge while busy sets
//   a one-deep pending flag, served after STOP. Simultaneous sources = one transaction.
// - FSM: IDLE -> START -> ADDR(8 bits {SLAVE_ADDR,rw}) -> ACK1 -> WR or RD (8 bits, MSB
//   first) -> ACK2 (slave ACK after WR) / MACK (master NACK after RD) -> STOP -> IDLE.
// - START: SDA low while SCL high, one quarter; SCL then goes low.
// - Each bit = 4 quarters: q0 SCL low, SDA updated; q1 SCL released; q2 sample SDA;
//   q3 SCL low.
// - ACK1/ACK2: master releases SDA and samples at q2. NACK (1) -> STOP directly.
//   On NACK, data_rd is unchanged.
// - MACK: master releases SDA for the 9th bit (NACK) to end the read.
// - data_rd loads the shifted byte on the clock where MACK completes; it holds otherwise.
// - STOP: SDA low, SCL released, then SDA released. Bus stays idle >= 4 quarters before
//   the next START.
// - rw is latched at START. Changes mid-transaction are ignored.
// - No clock stretching and no arbitration; SCL is never read back.
// - Reset mid-transaction: lines released on the next clock, partial byte discarded.
// - Display: data_rd -> hundreds/tens/units (0..255) via combinational or iterative BCD.
//   Digit 3 is always blank (seg=8'hFF). Leading zeros are shown.
//   Digit index advances 0->1->2->3->0 every REFRESH_CYC clocks.
// - Segment map, active-low {dp..a}:
//   0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90.
// TESTING (bench: pull-ups on SDA/SCL, behavioural slave at 0x48;
//          CLK 20 ns, QDIV=2, REFRESH_CYC=4)
// 1 reset_n=0 for 5 clks -> sda=scl=1 (released), data_rd=0, an=1110, seg=C0.
// 2 rw=1, ena2 pulse, slave returns 8'h19 -> bus sees START, 0x91, ACK, 0x19, NACK, STOP;
//   then data_rd=25 and digits show 0,2,5.
// 3 rw=0, ena=1 held, slave ACKs -> bytes 0x90, 0x00 repeat, each ended by STOP;
//   data_rd unchanged.
// 4 Slave NACKs the address -> STOP right after the 9th bit, data_rd keeps its previous
//   value.
// 5 ena2 toggling every 100 ns during a read -> exactly one extra transaction after STOP,
//   no overlap.
// 6 data_rd=255 -> an cycles 1110, 1101, 1011, 0111 with seg 92, 92, A4, FF;
//   reset mid-ADDR -> lines released next clk.

Source files
------------

// File: rtl/temp_sensor_i2c_top.sv
// Single-byte I2C master for a temperature sensor plus a 4-digit multiplexed
// 7-segment display that shows the last byte read as unsigned decimal.
module temp_sensor_i2c_top #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned I2C_HZ      = 100_000,
    parameter logic [6:0]  SLAVE_ADDR  = 7'h48,
    parameter logic [7:0]  WR_DATA     = 8'h00,
    parameter int unsigned REFRESH_CYC = 50_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ena,
    input  logic       ena2,
    input  logic       rw,
    output logic [7:0] data_rd,
    output logic [7:0] seg,
    output logic [3:0] an,
    inout  wire        sda,
    inout  wire        scl
);
    localparam int unsigned QDIV_RAW = CLK_HZ / (4 * I2C_HZ);
    localparam int unsigned QDIV     = (QDIV_RAW < 1) ? 1 : QDIV_RAW;
    localparam int unsigned QW       = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int unsigned RW       = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ACK1, S_WR, S_RD, S_ACK2, S_MACK, S_STOP
    } state_t;

    state_t         state_q, state_d;
    logic [QW-1:0]  qcnt_q, qcnt_d;
    logic [2:0]     qph_q, qph_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [7:0]     data_rd_q, data_rd_d;
    logic           rw_q, rw_d;
    logic           nack_q, nack_d;
    logic           pending_q, pending_d;
    logic           ena2_q, ena2_d;
    logic [1:0]     sda_sync_q, sda_sync_d;
    logic           sda_oe_q, sda_oe_d;
    logic           scl_oe_q, scl_oe_d;
    logic [RW-1:0]  ref_cnt_q, ref_cnt_d;
    logic [1:0]     digit_q, digit_d;

    logic tick, rise2, sda_in, scl_low_phase;
    logic [3:0] digit_val;

    // Open-drain pads: a set output-enable pulls the line low, otherwise released.
    assign sda     = sda_oe_q ? 1'b0 : 1'bz;
    assign scl     = scl_oe_q ? 1'b0 : 1'bz;
    assign data_rd = data_rd_q;

    always_comb begin
        tick       = (qcnt_q == QW'(QDIV - 1));
        rise2      = ena2 & ~ena2_q;
        sda_in     = sda_sync_q[1];
        ena2_d     = ena2;
        sda_sync_d = {sda_sync_q[0], sda};
        state_d    = state_q;
        qph_d      = qph_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        data_rd_d  = data_rd_q;
        rw_d       = rw_q;
        nack_d     = nack_q;
        pending_d  = pending_q | (rise2 & (state_q != S_IDLE));
        qcnt_d     = (state_q == S_IDLE || tick) ? '0 : qcnt_q + QW'(1);

        case (state_q)
            S_IDLE: begin
                if (ena | rise2 | pending_q) begin
                    state_d   = S_START;
                    qph_d     = 3'd0;
                    bit_d     = 3'd0;
                    rw_d      = rw;
                    shreg_d   = {SLAVE_ADDR, rw};
                    pending_d = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_ADDR;
                    qph_d   = 3'd0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (qph_q == 3'd7) state_d = S_IDLE;
                    qph_d = qph_q + 3'd1;
                end
            end
            default: begin
                if (tick) begin
                    qph_d = (qph_q == 3'd3) ? 3'd0 : qph_q + 3'd1;
                    if (qph_q == 3'd2) begin
                        if (state_q == S_RD) shreg_d = {shreg_q[6:0], sda_in};
                        if (state_q == S_ACK1 || state_q == S_ACK2) nack_d = sda_in;
                    end
                    if (qph_q == 3'd3) begin
                        case (state_q)
                            S_ADDR, S_WR: begin
                                shreg_d = {shreg_q[6:0], 1'b0};
                                bit_d   = bit_q + 3'd1;
                                if (bit_q == 3'd7) state_d = (state_q == S_ADDR) ? S_ACK1 : S_ACK2;
                            end
                            S_RD: begin
                                bit_d = bit_q + 3'd1;
                                if (bit_q == 3'd7) state_d = S_MACK;
                            end
                            S_ACK1: begin
                                if (nack_q)    state_d = S_STOP;
                                else if (rw_q) state_d = S_RD;
                                else begin
                                    state_d = S_WR;
                                    shreg_d = WR_DATA;
                                end
                            end
                            S_MACK: begin
                                state_d   = S_STOP;
                                data_rd_d = shreg_q;
                            end
                            default: state_d = S_STOP;
                        endcase
                    end
                end
            end
        endcase

        // Line drive is decoded from the next state so the pads change with the state.
        scl_low_phase = (qph_d == 3'd0) || (qph_d == 3'd3);
        sda_oe_d = 1'b0;
        scl_oe_d = 1'b0;
        case (state_d)
            S_START: sda_oe_d = 1'b1;
            S_ADDR, S_WR: begin
                scl_oe_d = scl_low_phase;
                sda_oe_d = ~shreg_d[7];
            end
            S_ACK1, S_ACK2, S_RD, S_MACK: scl_oe_d = scl_low_phase;
            S_STOP: begin
                scl_oe_d = (qph_d == 3'd0);
                sda_oe_d = (qph_d <= 3'd1);
            end
            default: ;
        endcase
    end

    always_comb begin
        ref_cnt_d = (ref_cnt_q == RW'(REFRESH_CYC - 1)) ? '0 : ref_cnt_q + RW'(1);
        digit_d   = (ref_cnt_q == RW'(REFRESH_CYC - 1)) ? digit_q + 2'd1 : digit_q;
        case (digit_q)
            2'd0:    digit_val = 4'(data_rd_q % 8'd10);
            2'd1:    digit_val = 4'((data_rd_q / 8'd10) % 8'd10);
            2'd2:    digit_val = 4'(data_rd_q / 8'd100);
            default: digit_val = 4'd0;
        endcase
        case (digit_val)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        if (digit_q == 2'd3) seg = 8'hFF;
        an = ~(4'b0001 << digit_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            qcnt_q     <= '0;
            qph_q      <= 3'd0;
            bit_q      <= 3'd0;
            shreg_q    <= 8'h00;
            data_rd_q  <= 8'h00;
            rw_q       <= 1'b0;
            nack_q     <= 1'b0;
            pending_q  <= 1'b0;
            ena2_q     <= 1'b0;
            sda_sync_q <= 2'b11;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            ref_cnt_q  <= '0;
            digit_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            qph_q      <= qph_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            data_rd_q  <= data_rd_d;
            rw_q       <= rw_d;
            nack_q     <= nack_d;
            pending_q  <= pending_d;
            ena2_q     <= ena2_d;
            sda_sync_q <= sda_sync_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
            ref_cnt_q  <= ref_cnt_d;
            digit_q    <= digit_d;
        end
    end
endmodule

// File: tb/tb_temp_sensor_i2c_top.sv
// Bench for temp_sensor_i2c_top: pulled-up bus, behavioural sensor slave at 0x48,
// scoreboard of expected bus bytes checked as the slave sees them.
module tb_temp_sensor_i2c_top;
    localparam int SL_IDLE = 0, SL_ADDR = 1, SL_ACKA = 2, SL_WDATA = 3;
    localparam int SL_ACKD = 4, SL_RDATA = 5, SL_MACK = 6, SL_WAIT = 7;

    logic       clk = 1'b0;
    logic       reset_n, ena, ena2, rw;
    logic [7:0] data_rd, seg;
    logic [3:0] an;
    wire        sda, scl;
    logic       slave_sda_low = 1'b0;

    pullup pu_sda (sda);
    pullup pu_scl (scl);
    assign sda = slave_sda_low ? 1'b0 : 1'bz;

    temp_sensor_i2c_top #(
        .CLK_HZ(50_000_000), .I2C_HZ(6_250_000), .SLAVE_ADDR(7'h48),
        .WR_DATA(8'h00), .REFRESH_CYC(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ena(ena), .ena2(ena2), .rw(rw),
        .data_rd(data_rd), .seg(seg), .an(an), .sda(sda), .scl(scl)
    );

    always #10 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rd_byte = 8'h00;
    logic       slave_nack = 1'b0;
    int start_cnt = 0, stop_cnt = 0, rise_cnt = 0, last_rises = 0, overlap_cnt = 0;
    int cyc = 0, last_stop_cyc = 0, min_gap = 1000000;
    logic stop_seen = 1'b0, mack_bit = 1'b0;
    int sl_phase = SL_IDLE, sl_bits = 0;
    logic [7:0] sl_sh = 8'h00;
    logic sl_rw = 1'b0, ps = 1'b1, pd = 1'b1, cs, cd;
    logic [3:0] an_pat[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_byte(input logic [7:0] b);
        check_eq("sb_depth", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_eq("bus_byte", b, exp_q.pop_front());
    endtask

    function automatic logic [7:0] seg_model(input int d);
        case (d)
            0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
            4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
            8: return 8'h80; 9: return 8'h90; default: return 8'hFF;
        endcase
    endfunction

    // Behavioural slave: samples the bus on the falling clock edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            cs = scl;
            cd = sda;
            if (!reset_n) begin
                sl_phase = SL_IDLE;
                slave_sda_low = 1'b0;
            end else if (ps && cs && pd && !cd) begin
                if (sl_phase != SL_IDLE) overlap_cnt++;
                if (stop_seen && (cyc - last_stop_cyc) < min_gap) min_gap = cyc - last_stop_cyc;
                start_cnt++;
                rise_cnt = 0;
                sl_phase = SL_ADDR;
                sl_bits  = 0;
                sl_sh    = 8'h00;
            end else if (ps && cs && !pd && cd) begin
                stop_cnt++;
                last_rises    = rise_cnt;
                sl_phase      = SL_IDLE;
                slave_sda_low = 1'b0;
                last_stop_cyc = cyc;
                stop_seen     = 1'b1;
            end else if (!ps && cs) begin
                rise_cnt++;
                if (sl_phase == SL_ADDR || sl_phase == SL_WDATA || sl_phase == SL_RDATA) begin
                    sl_sh = {sl_sh[6:0], cd};
                    sl_bits++;
                    if (sl_bits == 8) sb_byte(sl_sh);
                end else if (sl_phase == SL_MACK) begin
                    mack_bit = cd;
                end
            end else if (ps && !cs) begin
                case (sl_phase)
                    SL_ADDR: if (sl_bits == 8) begin
                        if (sl_sh[7:1] == 7'h48 && !slave_nack) begin
                            slave_sda_low = 1'b1;
                            sl_rw = sl_sh[0];
                            sl_phase = SL_ACKA;
                        end else sl_phase = SL_WAIT;
                    end
                    SL_ACKA: begin
                        sl_bits = 0;
                        sl_sh = 8'h00;
                        if (sl_rw) begin
                            sl_phase = SL_RDATA;
                            slave_sda_low = ~rd_byte[7];
                        end else begin
                            sl_phase = SL_WDATA;
                            slave_sda_low = 1'b0;
                        end
                    end
                    SL_WDATA: if (sl_bits == 8) begin
                        slave_sda_low = 1'b1;
                        sl_phase = SL_ACKD;
                    end
                    SL_ACKD: begin
                        slave_sda_low = 1'b0;
                        sl_phase = SL_WAIT;
                    end
                    SL_RDATA: begin
                        if (sl_bits < 8) slave_sda_low = ~rd_byte[7 - sl_bits];
                        else begin
                            slave_sda_low = 1'b0;
                            sl_phase = SL_MACK;
                        end
                    end
                    SL_MACK: sl_phase = SL_WAIT;
                    default: ;
                endcase
            end
            ps = cs;
            pd = cd;
        end
    end

    task automatic wait_stops(input int target, input int max_cyc);
        int k = 0;
        while (stop_cnt < target && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check_eq("stop_wait", stop_cnt >= target, 1);
    endtask

    task automatic pulse_ena2();
        @(negedge clk);
        ena2 = 1'b1;
        @(negedge clk);
        ena2 = 1'b0;
    endtask

    task automatic check_display(input logic [7:0] v);
        logic [7:0] exp_seg[4];
        int k = 0;
        exp_seg[0] = seg_model(v % 10);
        exp_seg[1] = seg_model((v / 10) % 10);
        exp_seg[2] = seg_model(v / 100);
        exp_seg[3] = 8'hFF;
        while (an !== 4'b1110 && k < 40) begin
            @(negedge clk);
            k++;
        end
        for (int d = 0; d < 4; d++) begin
            check_eq("an", an, an_pat[d]);
            check_eq("seg", seg, exp_seg[d]);
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin
        int base, sbase, k;
        reset_n = 1'b0; ena = 1'b0; ena2 = 1'b0; rw = 1'b0;

        // 1: reset state
        repeat (5) @(negedge clk);
        check_eq("rst_sda", sda, 1);
        check_eq("rst_scl", scl, 1);
        check_eq("rst_data_rd", data_rd, 0);
        check_eq("rst_an", an, 4'b1110);
        check_eq("rst_seg", seg, 8'hC0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // 2: single read via ena2 edge
        rw = 1'b1; rd_byte = 8'h19;
        exp_q.push_back(8'h91); exp_q.push_back(8'h19);
        pulse_ena2();
        wait_stops(1, 1000);
        repeat (20) @(negedge clk);
        check_eq("rd_data", data_rd, 8'h19);
        check_eq("rd_rises", last_rises, 19);
        check_eq("rd_mnack", mack_bit, 1);
        check_display(8'h19);

        // 3: writes repeat while ena is held
        rw = 1'b0;
        repeat (2) begin exp_q.push_back(8'h90); exp_q.push_back(8'h00); end
        base = stop_cnt;
        ena = 1'b1;
        wait_stops(base + 2, 2000);
        ena = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("wr_count", stop_cnt, base + 2);
        check_eq("wr_rises", last_rises, 19);
        check_eq("wr_data_rd", data_rd, 8'h19);
        check_eq("wr_gap", min_gap >= 8, 1);

        // 4: address NACK
        slave_nack = 1'b1; rw = 1'b1;
        exp_q.push_back(8'h91);
        base = stop_cnt;
        pulse_ena2();
        wait_stops(base + 1, 1000);
        repeat (40) @(negedge clk);
        check_eq("nack_rises", last_rises, 10);
        check_eq("nack_data_rd", data_rd, 8'h19);
        slave_nack = 1'b0;

        // 5: ena2 toggling during a read yields exactly one extra transaction
        rd_byte = 8'($urandom_range(0, 255));
        repeat (2) begin exp_q.push_back(8'h91); exp_q.push_back(rd_byte); end
        base = stop_cnt; sbase = start_cnt;
        @(negedge clk);
        ena2 = 1'b1;
        for (int i = 0; i < 15; i++) begin
            repeat (5) @(negedge clk);
            ena2 = ~ena2;
        end
        wait_stops(base + 2, 2000);
        repeat (300) @(negedge clk);
        check_eq("tog_stops", stop_cnt, base + 2);
        check_eq("tog_starts", start_cnt, sbase + 2);
        check_eq("tog_overlap", overlap_cnt, 0);
        check_eq("tog_data_rd", data_rd, rd_byte);
        check_eq("gap_min", min_gap >= 8, 1);

        // 6: 255 on the display, then reset in the middle of the address byte
        rd_byte = 8'hFF;
        exp_q.push_back(8'h91); exp_q.push_back(8'hFF);
        base = stop_cnt;
        pulse_ena2();
        wait_stops(base + 1, 1000);
        repeat (20) @(negedge clk);
        check_eq("ff_data", data_rd, 8'hFF);
        check_display(8'hFF);
        sbase = start_cnt;
        pulse_ena2();
        k = 0;
        while (!(start_cnt > sbase && rise_cnt >= 3 && scl === 1'b0) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_eq("pre_rst_scl", scl, 0);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_sda", sda, 1);
        check_eq("mid_rst_scl", scl, 1);
        check_eq("mid_rst_data", data_rd, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
